// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage core. It produces every
// stall, flush and bubble for IF/ID, ID/EX, EX/MEM and MEM/WB. It covers
// load-use hazards, EX-resolved branch mispredicts and multi-cycle data
// memory waits. A watchdog halts the pipeline when memory hangs.
//
// The outputs are combinational from the state and the current inputs, so
// the pipeline reacts in the same cycle as the event. While reset_n is low,
// every output is forced to 0.
//
// Optional feature macro: HAZARD_PERF_EN
//   Defined  : perf_stall_cnt and perf_flush_cnt count the cycles with
//              pc_stall and ifid_flush, wrapping modulo 2^CNT_W.
//   Undefined: there are no counter flops and both ports are tied to 0.
//
// The state port exposes the FSM directly (RUN=00, MEM_WAIT=01, HALT=10).
module hazard_stall_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mispredict,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic                  memwb_bubble,
  output logic                  timeout_err,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  // The wait counter only needs to reach TIMEOUT-1. It stops there, so it
  // never wraps.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              pend_flush_q, pend_flush_d;
  logic              timeout_err_q, timeout_err_d;

  logic lu;        // load-use hazard between ID and EX
  logic ms;        // memory stage is waiting on data memory
  logic hold_all;  // freeze the whole pipeline
  logic do_flush;  // squash the wrong-path IF/ID and ID/EX contents
  logic do_lu;     // hold the front end and insert one bubble into EX

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
  assign ms = mem_req && !mem_ready;

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      pend_flush_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pend_flush_q  <= pend_flush_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and hazard decision. A mispredict seen during a memory wait
  // is remembered in pend_flush. It is applied on the exit cycle, because
  // the frozen pipeline cannot redirect until then.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pend_flush_d  = pend_flush_q;
    timeout_err_d = timeout_err_q;
    hold_all      = 1'b0;
    do_flush      = 1'b0;
    do_lu         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ms) begin
          hold_all     = 1'b1;
          pend_flush_d = ex_mispredict;
          wait_cnt_d   = '0;
          state_d      = ST_MEM_WAIT;
        end else if (ex_mispredict) begin
          do_flush = 1'b1;
        end else if (lu) begin
          do_lu = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          hold_all     = 1'b1;
          pend_flush_d = pend_flush_q | ex_mispredict;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ST_HALT;
            timeout_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d      = ST_RUN;
          pend_flush_d = 1'b0;
          if (pend_flush_q || ex_mispredict) begin
            do_flush = 1'b1;
          end else if (lu) begin
            do_lu = 1'b1;
          end
        end
      end
      ST_HALT: begin
        hold_all = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode. The reset_n gating keeps every output at 0 during reset,
  // whatever the inputs are doing.
  always_comb begin
    pc_stall     = reset_n & (hold_all | do_lu);
    ifid_stall   = reset_n & (hold_all | do_lu);
    ifid_flush   = reset_n & do_flush;
    idex_stall   = reset_n & hold_all;
    idex_flush   = reset_n & (do_flush | do_lu);
    exmem_stall  = reset_n & hold_all;
    memwb_bubble = reset_n & hold_all;
    timeout_err  = reset_n & timeout_err_q;
    state        = state_q;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Performance counters: cycles with the PC held and cycles with a flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall)   stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Testbench for hazard_stall_controller.
// The driver applies one input vector per cycle, just after the rising
// edge. A behavioural model then predicts the outputs for that cycle and
// pushes them into exp_q. A monitor on the falling edge pops each entry
// and compares it with the DUT outputs.
module tb_hazard_stall_controller;
  localparam int RW      = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;
  localparam int EW      = 10 + 2 * CNT_W;

  logic             clk;
  logic             reset_n;
  logic [RW-1:0]    id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_mispredict;
  logic             mem_req, mem_ready;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic             exmem_stall, memwb_bubble, timeout_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

  hazard_stall_controller #(
    .REG_ADDR_W(RW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble),
    .timeout_err(timeout_err), .state(state),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset_n       = 1'b0;
    id_rs1        = '0;
    id_rs2        = '0;
    ex_rd         = '0;
    id_use_rs1    = 1'b0;
    id_use_rs2    = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mispredict = 1'b0;
    mem_req       = 1'b0;
    mem_ready     = 1'b0;
  end

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  // Reference model state: 0=run, 1=waiting on memory, 2=halted
  int               m_mode   = 0;
  int               m_waited = 0;
  bit               m_pend   = 0;
  bit               m_err    = 0;
  logic [CNT_W-1:0] m_stalls = '0;
  logic [CNT_W-1:0] m_flush  = '0;

  // Drive one cycle of inputs, then predict the outputs for that cycle.
  task automatic drive(input logic rn, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input logic u1,
                       input logic u2, input logic [RW-1:0] rd,
                       input logic mr, input logic misp,
                       input logic mreq, input logic mrdy);
    bit               lu, ms, hold, flush, lst;
    logic [1:0]       cur_mode;
    logic [CNT_W-1:0] cur_st, cur_fl;
    logic [EW-1:0]    e;
    @(posedge clk);
    #1;
    reset_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1;
    id_use_rs2 = u2; ex_rd = rd; ex_mem_read = mr; ex_mispredict = misp;
    mem_req = mreq; mem_ready = mrdy;
    cycle++;
    if (!rn) begin
      m_mode = 0; m_waited = 0; m_pend = 0; m_err = 0;
      m_stalls = '0; m_flush = '0;
      e = '0;
    end else begin
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      ms = mreq && !mrdy;
      hold = 0; flush = 0; lst = 0;
      cur_mode = 2'(m_mode);
`ifdef HAZARD_PERF_EN
      cur_st = m_stalls;
      cur_fl = m_flush;
`else
      cur_st = '0;
      cur_fl = '0;
`endif
      e = {8'b0, cur_mode, cur_st, cur_fl};
      e[EW-8] = m_err;
      if (m_mode == 0) begin
        if (ms) begin
          hold = 1; m_pend = misp; m_waited = 0; m_mode = 1;
        end else if (misp) flush = 1;
        else if (lu) lst = 1;
      end else if (m_mode == 1) begin
        if (!mrdy) begin
          hold = 1;
          m_pend = m_pend | misp;
          m_waited++;
          if (m_waited >= TIMEOUT) begin
            m_mode = 2; m_err = 1;
          end
        end else begin
          m_mode = 0;
          if (m_pend || misp) flush = 1;
          else if (lu) lst = 1;
          m_pend = 0;
        end
      end else begin
        hold = 1;
      end
      e[EW-1] = hold | lst;
      e[EW-2] = hold | lst;
      e[EW-3] = flush;
      e[EW-4] = hold;
      e[EW-5] = flush | lst;
      e[EW-6] = hold;
      e[EW-7] = hold;
      m_stalls = m_stalls + CNT_W'(hold | lst);
      m_flush  = m_flush + CNT_W'(flush);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input bit hang);
    drive(1, RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 5) == 0,
          hang ? 1'b1 : ($urandom_range(0, 2) == 0),
          hang ? 1'b0 : ($urandom_range(0, 3) != 0));
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation
  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, memwb_bubble, timeout_err, state,
             perf_stall_cnt, perf_flush_cnt};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle %0d outputs: got %h expected %h", cycle, a, e);
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 5, 0, 1, 0, 5, 1, 1, 1, 0);   // hazard inputs during reset
    // Load-use on rs1, then the same with ex_rd = x0
    drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    // Load-use on rs2, then a mispredict in the same cycle as a load-use
    drive(1, 1, 7, 0, 1, 7, 1, 0, 0, 0);
    drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    idle(1);
    // Memory wait of three cycles
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // Deferred flush: mispredict in wait cycle 1, exit in cycle 4
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // Watchdog timeout, then inputs are ignored in HALT, then async reset
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Randomized rounds, each ending with a hang and a reset
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 250; i++) rand_cycle(0);
      for (int i = 0; i < 8; i++) rand_cycle(1);
      for (int i = 0; i < 3; i++) rand_cycle(0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
